// File: rtl/teatris_pkg.sv
// Shared definitions for the Teatris display controller: FSM states, ROM address and map geometry.
package teatris_pkg;

  typedef enum logic [1:0] {
    JOGO    = 2'd0,
    CARREGA = 2'd1,
    PISCA   = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam logic [3:0] ENDERECO_FIM = 4'd15;
  localparam int         N_LINHAS     = 8;
  localparam int         N_COLUNAS    = 8;
  localparam int         W_LINHA      = 3;

  // Row 0 lives in the top byte, so shift the wanted row up to [63:56].
  function automatic logic [N_COLUNAS-1:0] fatia_linha(input logic [63:0] mapa,
                                                       input logic [W_LINHA-1:0] linha);
    logic [63:0] w_desloc;
    w_desloc = mapa << {linha, 3'b000};
    return w_desloc[63:56];
  endfunction

endpackage

// File: rtl/teatris_varredura.sv
// Free-running row scan: prescaler wraps every DIV_VARREDURA cycles and advances the row index.
module teatris_varredura
  import teatris_pkg::*;
#(
  parameter int DIV_VARREDURA = 1000
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [W_LINHA-1:0] r,
  output logic               tick,
  output logic               fim_quadro
);

  localparam logic [15:0] PRESC_MAX = 16'(DIV_VARREDURA - 1);

  logic [15:0]        r_presc;
  logic [W_LINHA-1:0] r_linha;

  assign tick       = (r_presc == PRESC_MAX);
  assign fim_quadro = tick && (r_linha == 3'd7);
  assign r          = r_linha;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_linha <= '0;
    end else if (tick) begin
      r_presc <= '0;
      r_linha <= r_linha + 3'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

endmodule

// File: rtl/teatris_controle_exibicao.sv
// Display controller: live game map, then ROM game-over pattern fetched, blinked and held until restart.
// States: JOGO live map | CARREGA fetch ROM (2 cycles) | PISCA blink buffer | FIM steady buffer
module teatris_controle_exibicao
  import teatris_pkg::*;
#(
  parameter int DIV_VARREDURA = 1000,
  parameter int QUADROS_PISCA = 25,
  parameter int N_PISCAS      = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 fim_jogo,
  input  logic                 reinicio,
  input  logic [63:0]          mapa_jogo,
  output logic [3:0]           rom_endereco,
  input  logic [63:0]          rom_padrao,
  output logic [N_LINHAS-1:0]  linhas,
  output logic [N_COLUNAS-1:0] colunas,
  output logic                 em_fim
);

  localparam logic [7:0] QUADRO_MAX = 8'(QUADROS_PISCA - 1);
  localparam logic [4:0] PISCA_MAX  = 5'(2 * N_PISCAS - 1);

  estado_t              r_estado;
  estado_t              w_estado_prox;
  logic                 r_em_fim;
  logic                 r_carga_seg;
  logic [63:0]          r_buffer;
  logic                 r_visivel;
  logic [7:0]           r_cnt_quadro;
  logic [4:0]           r_cnt_pisca;
  logic [N_LINHAS-1:0]  r_linhas;
  logic [N_COLUNAS-1:0] r_colunas;
  logic [63:0]          w_fonte;
  logic [W_LINHA-1:0]   w_linha;
  logic                 w_tick;
  logic                 w_fim_quadro;
  logic                 w_troca;
  logic                 w_fim_pisca;

  teatris_varredura #(.DIV_VARREDURA(DIV_VARREDURA)) u_varredura (
    .clock      (clock),
    .reset_n    (reset_n),
    .r          (w_linha),
    .tick       (w_tick),
    .fim_quadro (w_fim_quadro)
  );

  assign w_troca      = w_fim_quadro && (r_cnt_quadro == QUADRO_MAX);
  assign w_fim_pisca  = w_troca && (r_cnt_pisca == PISCA_MAX);
  assign rom_endereco = (r_estado == CARREGA) ? ENDERECO_FIM : 4'd0;
  assign linhas       = r_linhas;
  assign colunas      = r_colunas;
  assign em_fim       = r_em_fim;

  always_comb begin
    w_estado_prox = r_estado;
    w_fonte       = mapa_jogo;
    case (r_estado)
      JOGO: begin
        if (fim_jogo) w_estado_prox = CARREGA;
      end
      CARREGA: begin
        w_fonte = 64'h0;  // blank while the ROM is being read; PISCA also opens blank
        if (r_carga_seg) w_estado_prox = PISCA;
      end
      PISCA: begin
        w_fonte = r_visivel ? r_buffer : 64'h0;
        if (w_fim_pisca) w_estado_prox = FIM;
      end
      FIM: begin
        w_fonte = r_buffer;
        if (reinicio) w_estado_prox = JOGO;
      end
      default: w_estado_prox = JOGO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= JOGO;
      r_em_fim <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      r_em_fim <= (w_estado_prox != JOGO);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_carga_seg  <= 1'b0;
      r_buffer     <= '0;
      r_visivel    <= 1'b0;
      r_cnt_quadro <= '0;
      r_cnt_pisca  <= '0;
      r_linhas     <= 8'b0000_0001;
      r_colunas    <= '0;
    end else begin
      r_linhas  <= 8'd1 << w_linha;
      r_colunas <= fatia_linha(w_fonte, w_linha);
      case (r_estado)
        JOGO: r_carga_seg <= 1'b0;
        CARREGA: begin
          r_carga_seg <= 1'b1;
          if (r_carga_seg) begin
            r_buffer     <= rom_padrao;
            r_visivel    <= 1'b0;
            r_cnt_quadro <= '0;
            r_cnt_pisca  <= '0;
          end
        end
        PISCA: begin
          if (w_troca) begin
            r_cnt_quadro <= '0;
            r_visivel    <= ~r_visivel;
            r_cnt_pisca  <= r_cnt_pisca + 5'd1;
          end else if (w_fim_quadro) begin
            r_cnt_quadro <= r_cnt_quadro + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_teatris_controle_exibicao.sv
// Randomized bench for the Teatris display controller against a frame-arithmetic reference model.
module tb_teatris_controle_exibicao;

  localparam int          DIV       = 4;
  localparam int          QP        = 1;
  localparam int          NP        = 3;
  localparam logic [63:0] PADRAO    = 64'h085C_FE0F_FF0F_BF0F;
  localparam logic [63:0] MAPA_DIAG = 64'h0102_0408_1020_4080;
  localparam int M_JOGO = 0, M_CARREGA = 1, M_PISCA = 2, M_FIM = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fim_jogo = 1'b0;
  logic        reinicio = 1'b0;
  logic [63:0] mapa_jogo = '0;
  logic [63:0] rom_padrao = '0;
  logic [3:0]  rom_endereco;
  logic [7:0]  linhas;
  logic [7:0]  colunas;
  logic        em_fim;

  int n_erros = 0;
  int n_checks = 0;

  // reference model: scan position derived from edges since reset, blink phase from frame-ends since PISCA entry
  int          m_k, m_modo, m_carga, m_f;
  logic [63:0] m_buf;
  logic [7:0]  m_lin, m_col;
  logic        m_em_fim;
  logic        ja_resetou = 1'b0;

  teatris_controle_exibicao #(
    .DIV_VARREDURA (DIV),
    .QUADROS_PISCA (QP),
    .N_PISCAS      (NP)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fim_jogo     (fim_jogo),
    .reinicio     (reinicio),
    .mapa_jogo    (mapa_jogo),
    .rom_endereco (rom_endereco),
    .rom_padrao   (rom_padrao),
    .linhas       (linhas),
    .colunas      (colunas),
    .em_fim       (em_fim)
  );

  always #5 clock = ~clock;

  // registered ROM: only address 15 holds the game-over pattern
  always @(posedge clock)
    rom_padrao <= (rom_endereco == 4'd15) ? PADRAO : {32'hDEAD_BEEF, 28'h0, rom_endereco};

  task automatic confere(input string tag, input logic [63:0] obtido, input logic [63:0] esperado);
    n_checks++;
    if (obtido !== esperado) begin
      n_erros++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, obtido, esperado, $time);
    end
  endtask

  task automatic modelo_reset();
    m_k = 0; m_modo = M_JOGO; m_carga = 0; m_f = 0;
    m_buf = '0; m_lin = 8'h01; m_col = 8'h00; m_em_fim = 1'b0;
  endtask

  function automatic logic [63:0] fonte_modelo();
    case (m_modo)
      M_JOGO:  return mapa_jogo;
      M_PISCA: return (((m_f / QP) % 2) == 1) ? m_buf : 64'h0;
      M_FIM:   return m_buf;
      default: return 64'h0;
    endcase
  endfunction

  task automatic passo_modelo();
    int          row;
    logic        fe;
    logic [63:0] src;
    if (!reset_n) begin
      modelo_reset();
    end else begin
      row = (m_k / DIV) % 8;
      fe  = ((m_k % DIV) == DIV - 1) && (row == 7);
      src = fonte_modelo();
      m_lin = 8'(1 << row);
      m_col = 8'(src >> (8 * (7 - row)));
      case (m_modo)
        M_JOGO: if (fim_jogo) begin m_modo = M_CARREGA; m_carga = 0; end
        M_CARREGA: begin
          m_carga++;
          if (m_carga == 2) begin m_modo = M_PISCA; m_buf = PADRAO; m_f = 0; end
        end
        M_PISCA: if (fe) begin
          m_f++;
          if (m_f == 2 * NP * QP) m_modo = M_FIM;
        end
        default: if (reinicio) m_modo = M_JOGO;
      endcase
      m_em_fim = (m_modo != M_JOGO);
      m_k++;
    end
  endtask

  task automatic verifica();
    logic [3:0] er;
    er = (m_modo == M_CARREGA) ? 4'd15 : 4'd0;
    confere("linhas", 64'(linhas), 64'(m_lin));
    confere("colunas", 64'(colunas), 64'(m_col));
    confere("em_fim", 64'(em_fim), 64'(m_em_fim));
    confere("rom_endereco", 64'(rom_endereco), 64'(er));
  endtask

  task automatic aplica_estimulo(input int estilo);
    if (estilo == 0) begin
      mapa_jogo = MAPA_DIAG; fim_jogo = 1'b0; reinicio = 1'($urandom_range(0, 1));
    end else if (estilo == 2) begin
      mapa_jogo = {$urandom(), $urandom()}; fim_jogo = 1'b1; reinicio = 1'b1;
    end else begin
      mapa_jogo = {$urandom(), $urandom()};
      case (m_modo)
        M_JOGO: begin
          fim_jogo = ($urandom_range(0, 19) == 0);
          reinicio = 1'($urandom_range(0, 1));
        end
        M_FIM: begin
          fim_jogo = 1'($urandom_range(0, 1));
          reinicio = ($urandom_range(0, 29) == 0);
        end
        default: begin
          fim_jogo = 1'($urandom_range(0, 1));
          reinicio = 1'($urandom_range(0, 1));
        end
      endcase
    end
  endtask

  task automatic ciclo(input int estilo);
    @(posedge clock);
    passo_modelo();
    @(negedge clock);
    verifica();
    aplica_estimulo(estilo);
  endtask

  initial begin
    modelo_reset();
    repeat (3) ciclo(0);
    reset_n = 1'b1;

    repeat (64) ciclo(0);

    for (int i = 0; i < 2500; i++) begin
      ciclo(1);
      if (!ja_resetou && m_modo == M_PISCA && m_f >= 2) begin
        ja_resetou = 1'b1;
        #1 reset_n = 1'b0;
        modelo_reset();
        #1 verifica();
        ciclo(1);
        reset_n = 1'b1;
      end
    end

    repeat (600) ciclo(2);

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule
